// File: rtl/pci_bus_arbiter.sv
// Round-robin PCI bus arbiter: one-hot active-low grants, turnaround gap, unused-grant timeout.
// Optional bus parking on the last owner is enabled by defining ARB_BUS_PARK_EN.
module pci_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int GNT_TIMEOUT = 16,
  parameter int MW          = 2
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic [NUM_MASTERS-1:0] REQn,
  input  logic                   FRAMEn,
  input  logic                   IRDYn,
  output logic [NUM_MASTERS-1:0] GNTn,
  output logic [MW-1:0]          CUR_MASTER,
  output logic                   BUS_IDLE,
  output logic                   ARB_TIMEOUT
);

  localparam int CW = $clog2(GNT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    GNT_WAIT,
    BUSY,
`ifdef ARB_BUS_PARK_EN
    PARK,
`endif
    GAP
  } state_t;

  state_t          state;
  logic [MW-1:0]   rr_ptr;
  logic [CW-1:0]   cnt;
  logic [MW-1:0]   winner;
  logic            any_req;
  logic            bidle;

  function automatic logic [MW-1:0] next_idx(input logic [MW-1:0] i);
    return (int'(i) == NUM_MASTERS - 1) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [NUM_MASTERS-1:0] onehot_low(input logic [MW-1:0] i);
    return ~(NUM_MASTERS'(1) << i);
  endfunction

  assign bidle = FRAMEn & IRDYn;

  // First requester found scanning upward from rr_ptr, wrapping at NUM_MASTERS.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (!any_req && !REQn[MW'((int'(rr_ptr) + i) % NUM_MASTERS)]) begin
        any_req = 1'b1;
        winner  = MW'((int'(rr_ptr) + i) % NUM_MASTERS);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state       <= IDLE;
      GNTn        <= '1;
      CUR_MASTER  <= '0;
      BUS_IDLE    <= 1'b1;
      ARB_TIMEOUT <= 1'b0;
      rr_ptr      <= '0;
      cnt         <= '0;
    end else begin
      BUS_IDLE    <= bidle;
      ARB_TIMEOUT <= 1'b0;
      case (state)
        IDLE: begin
          if (bidle && any_req) begin
            GNTn       <= onehot_low(winner);
            CUR_MASTER <= winner;
            cnt        <= '0;
            state      <= GNT_WAIT;
          end
`ifdef ARB_BUS_PARK_EN
          else if (bidle) begin
            GNTn  <= onehot_low(CUR_MASTER);
            state <= PARK;
          end
`endif
        end
        GNT_WAIT: begin
          if (!FRAMEn) begin
            rr_ptr <= next_idx(CUR_MASTER);
            state  <= BUSY;
          end else if (REQn[CUR_MASTER]) begin
            GNTn  <= '1;
            state <= GAP;
          end else if (cnt == CW'(GNT_TIMEOUT - 1)) begin
            GNTn        <= '1;
            ARB_TIMEOUT <= 1'b1;
            rr_ptr      <= next_idx(CUR_MASTER);
            state       <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BUSY: begin
          if (bidle) begin
            GNTn  <= '1;
            state <= GAP;
          end
        end
`ifdef ARB_BUS_PARK_EN
        // A parked owner may start directly; its own request turns the park into a timed grant.
        PARK: begin
          if (!FRAMEn) begin
            state <= BUSY;
          end else if ((~REQn & onehot_low(CUR_MASTER)) != '0) begin
            GNTn  <= '1;
            state <= GAP;
          end else if (!REQn[CUR_MASTER] && bidle) begin
            cnt   <= '0;
            state <= GNT_WAIT;
          end
        end
`endif
        GAP: state <= IDLE;
        default: begin
          GNTn  <= '1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed-vector bench for pci_bus_arbiter: stimulus queues expected outputs, a monitor checks them.
// Define ARB_BUS_PARK_EN for both RTL and bench to run the parking sequence instead.
module tb_pci_bus_arbiter;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic [3:0] REQn;
  logic       FRAMEn;
  logic       IRDYn;
  logic [3:0] GNTn;
  logic [1:0] CUR_MASTER;
  logic       BUS_IDLE;
  logic       ARB_TIMEOUT;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] cur;
    logic       idle;
    logic       to;
    string      name;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  pci_bus_arbiter #(.NUM_MASTERS(4), .GNT_TIMEOUT(16), .MW(2)) dut (
    .CLK(CLK), .RSTn(RSTn), .REQn(REQn), .FRAMEn(FRAMEn), .IRDYn(IRDYn),
    .GNTn(GNTn), .CUR_MASTER(CUR_MASTER), .BUS_IDLE(BUS_IDLE), .ARB_TIMEOUT(ARB_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  // Drive one clock of inputs and queue the outputs expected after that rising edge.
  task automatic step(input logic rst, input logic [3:0] req, input logic f, input logic i,
                      input logic [3:0] gnt, input logic [1:0] cur, input logic to,
                      input string name);
    exp_t e;
    RSTn   = rst;
    REQn   = req;
    FRAMEn = f;
    IRDYn  = i;
    e.gnt  = gnt;
    e.cur  = cur;
    e.idle = rst ? (f & i) : 1'b1;
    e.to   = to;
    e.name = name;
    q.push_back(e);
    @(negedge CLK);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() != 0) begin
        e = q.pop_front();
        vectors++;
        if (GNTn !== e.gnt || CUR_MASTER !== e.cur || BUS_IDLE !== e.idle || ARB_TIMEOUT !== e.to) begin
          miscompares++;
          $display("FAIL %s: gnt/cur/idle/to got %b/%0d/%b/%b expected %b/%0d/%b/%b",
                   e.name, GNTn, CUR_MASTER, BUS_IDLE, ARB_TIMEOUT, e.gnt, e.cur, e.idle, e.to);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, %0d vectors applied", vectors);
    $fatal(1, "watchdog");
  end

  logic [3:0] rr_gnt[5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
  logic [1:0] rr_cur[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    RSTn = 1'b0; REQn = 4'b1111; FRAMEn = 1'b1; IRDYn = 1'b1;
    step(0, 4'b1111, 1, 1, 4'b1111, 0, 0, "reset1");
    step(0, 4'b1111, 1, 1, 4'b1111, 0, 0, "reset2");
`ifdef ARB_BUS_PARK_EN
    step(1, 4'b1101, 1, 1, 4'b1101, 1, 0, "pk_grant1");
    step(1, 4'b1111, 0, 0, 4'b1101, 1, 0, "pk_busy1");
    step(1, 4'b1111, 1, 1, 4'b1111, 1, 0, "pk_gap1");
    step(1, 4'b1111, 1, 1, 4'b1111, 1, 0, "pk_idle1");
    step(1, 4'b1111, 1, 1, 4'b1101, 1, 0, "pk_park1");
    step(1, 4'b1111, 1, 1, 4'b1101, 1, 0, "pk_park1_hold");
    step(1, 4'b1110, 1, 1, 4'b1111, 1, 0, "pk_drop");
    step(1, 4'b1110, 1, 1, 4'b1111, 1, 0, "pk_drop_idle");
    step(1, 4'b1110, 1, 1, 4'b1110, 0, 0, "pk_grant0");
    step(1, 4'b1111, 1, 1, 4'b1111, 0, 0, "pk_withdraw0");
    step(1, 4'b1111, 1, 1, 4'b1111, 0, 0, "pk_idle0");
    step(1, 4'b1111, 1, 1, 4'b1110, 0, 0, "pk_park0");
    step(1, 4'b1111, 0, 0, 4'b1110, 0, 0, "pk_park_busy");
    step(1, 4'b1111, 1, 1, 4'b1111, 0, 0, "pk_park_end");
`else
    // Single master 1 transaction: FRAMEn low 3 clocks, IRDYn low 4 clocks.
    step(1, 4'b1101, 1, 1, 4'b1101, 1, 0, "t2_grant");
    step(1, 4'b1111, 0, 1, 4'b1101, 1, 0, "t2_frame");
    step(1, 4'b1111, 0, 0, 4'b1101, 1, 0, "t2_busy_a");
    step(1, 4'b1111, 0, 0, 4'b1101, 1, 0, "t2_busy_b");
    step(1, 4'b1111, 1, 0, 4'b1101, 1, 0, "t2_busy_c");
    step(1, 4'b1111, 1, 0, 4'b1101, 1, 0, "t2_busy_d");
    step(1, 4'b1111, 1, 1, 4'b1111, 1, 0, "t2_release");
    step(1, 4'b1111, 1, 1, 4'b1111, 1, 0, "t2_gap");
    step(1, 4'b1111, 1, 1, 4'b1111, 1, 0, "t2_idle");

    step(0, 4'b1111, 1, 1, 4'b1111, 0, 0, "t3_reset");
    for (int m = 0; m < 5; m++) begin
      step(1, 4'b0000, 1, 1, rr_gnt[m], rr_cur[m], 0, "t3_grant");
      step(1, 4'b0000, 0, 0, rr_gnt[m], rr_cur[m], 0, "t3_data1");
      step(1, 4'b0000, 1, 0, rr_gnt[m], rr_cur[m], 0, "t3_data2");
      step(1, 4'b0000, 1, 1, 4'b1111, rr_cur[m], 0, "t3_release");
      step(1, 4'b0000, 1, 1, 4'b1111, rr_cur[m], 0, "t3_gap");
    end

    step(1, 4'b0111, 1, 1, 4'b0111, 3, 0, "t4_grant");
    for (int k = 0; k < 15; k++)
      step(1, 4'b0111, 1, 1, 4'b0111, 3, 0, "t4_wait");
    step(1, 4'b0111, 1, 1, 4'b1111, 3, 1, "t4_timeout");
    step(1, 4'b0110, 1, 1, 4'b1111, 3, 0, "t4_gap");
    step(1, 4'b0110, 1, 1, 4'b1110, 0, 0, "t4_rotated");
    step(1, 4'b1111, 1, 1, 4'b1111, 0, 0, "t4_withdraw");
    step(1, 4'b1111, 1, 1, 4'b1111, 0, 0, "t4_idle");

    step(1, 4'b1011, 1, 1, 4'b1011, 2, 0, "t5_grant");
    step(1, 4'b1011, 0, 0, 4'b1011, 2, 0, "t5_busy");
    step(0, 4'b1011, 0, 0, 4'b1111, 0, 0, "t5_reset");
    step(1, 4'b0101, 1, 1, 4'b1101, 1, 0, "t5_rr_cleared");
    step(1, 4'b1111, 1, 1, 4'b1111, 1, 0, "t5_withdraw");
    step(1, 4'b1111, 1, 1, 4'b1111, 1, 0, "t5_idle");

    step(1, 4'b1110, 0, 1, 4'b1111, 1, 0, "frame_in_idle");
    step(1, 4'b1110, 1, 1, 4'b1110, 0, 0, "grant_after_idle");
    step(1, 4'b1111, 1, 1, 4'b1111, 0, 0, "final_withdraw");
`endif
    repeat (2) @(negedge CLK);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
